// File: rtl/rshift_rx_if.sv
// Bundle for the serial receive link: serial input side plus the parallel
// valid/ready word port and status flags.
interface rshift_rx_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             sin;
  logic             sin_en;
  logic             clear;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic [CNT_W-1:0] bit_cnt;
  logic             busy;
  logic             overrun;

  modport master (
    output sin, sin_en, clear, pout_ready,
    input  pout, pout_valid, bit_cnt, busy, overrun
  );

  modport slave (
    input  sin, sin_en, clear, pout_ready,
    output pout, pout_valid, bit_cnt, busy, overrun
  );
endinterface

// File: rtl/rshift_rx.sv
// Serial-in/parallel-out receiver: LSB-first right shift, word presented on a
// valid/ready port, sticky overrun when a finished word finds the port full.
module rshift_rx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic        clk,
  input  logic        rstn,
  rshift_rx_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pout_q,  pout_d;
  logic             vld_q,   vld_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             ovr_q,   ovr_d;
  logic [WIDTH-1:0] word;
  logic             last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      pout_q  <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pout_q  <= pout_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pout_d  = pout_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    word    = {bus.sin, shreg_q[WIDTH-1:1]};
    last    = (cnt_q == CNT_W'(WIDTH-1));

    if (bus.clear) begin
      // pout deliberately survives a flush; only the flags and partial word go
      shreg_d = '0;
      cnt_d   = '0;
      state_d = IDLE;
      vld_d   = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (vld_q && bus.pout_ready) vld_d = 1'b0;
      if (bus.sin_en) begin
        shreg_d = word;
        unique case (state_q)
          IDLE: begin
            state_d = SHIFT;
            cnt_d   = CNT_W'(1);
          end
          SHIFT: begin
            if (last) begin
              state_d = IDLE;
              cnt_d   = '0;
              // an accept on this same edge frees the port for the new word
              if (!vld_q || bus.pout_ready) begin
                pout_d = word;
                vld_d  = 1'b1;
              end else begin
                ovr_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign bus.pout       = pout_q;
  assign bus.pout_valid = vld_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_rshift_rx.sv
// Directed bench for rshift_rx: expected words queued as they are sent and
// compared when the consumer takes them.
module tb_rshift_rx;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  logic [WIDTH-1:0] exp_q[$];

  rshift_rx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  rshift_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Consumption happens on the coming edge if valid&ready hold now.
  task automatic tick();
    logic [WIDTH-1:0] e;
    if (bus.pout_valid === 1'b1 && bus.pout_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_word", {24'd0, bus.pout}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("accepted_word", {24'd0, bus.pout}, {24'd0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bus.sin    = w[i];
      bus.sin_en = 1'b1;
      tick();
    end
    bus.sin_en = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] e;
    checks = 0;
    errors = 0;
    bus.sin = 1'b0; bus.sin_en = 1'b0; bus.clear = 1'b0; bus.pout_ready = 1'b0;
    rstn = 1'b0;

    // reset / idle
    tick(); tick();
    chk("rst_pout", {24'd0, bus.pout}, 32'h0);
    chk("rst_valid", {31'd0, bus.pout_valid}, 32'h0);
    rstn = 1'b1;
    repeat (5) tick();
    chk("idle_flags", {bus.busy, bus.overrun, bus.pout_valid}, 32'h0);
    chk("idle_cnt", {29'd0, bus.bit_cnt}, 32'h0);

    // single word, then accept
    send_bits(8'h01, 1);
    chk("first_bit_busy", {bus.busy, bus.bit_cnt}, {28'd0, 1'b1, 3'd1});
    send_bits(8'h00, 7);
    chk("single_pout", {24'd0, bus.pout}, 32'h01);
    chk("single_state", {bus.pout_valid, bus.busy, bus.bit_cnt}, {27'd0, 1'b1, 1'b0, 3'd0});
    exp_q.push_back(8'h01);
    bus.pout_ready = 1'b1;
    tick();
    bus.pout_ready = 1'b0;
    chk("single_acc", {23'd0, bus.pout_valid, bus.pout}, {23'd0, 1'b0, 8'h01});

    // back-to-back streaming at full rate
    bus.pout_ready = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    for (int i = 0; i < 16; i++) begin
      e = (i < 8) ? 8'hA5 : 8'h3C;
      bus.sin    = e[i % 8];
      bus.sin_en = 1'b1;
      tick();
      if (i == 7)  chk("stream_w0", {23'd0, bus.pout_valid, bus.pout}, {23'd0, 1'b1, 8'hA5});
      if (i == 8)  chk("stream_gap_valid", {31'd0, bus.pout_valid}, 32'h0);
      if (i == 15) chk("stream_w1", {23'd0, bus.pout_valid, bus.pout}, {23'd0, 1'b1, 8'h3C});
    end
    bus.sin_en = 1'b0;
    tick();
    bus.pout_ready = 1'b0;
    chk("stream_drain", {bus.overrun, bus.pout_valid}, 32'h0);

    // overrun: second word dropped while port is full
    exp_q.push_back(8'h11);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    e = exp_q.pop_front();
    chk("ovr_pout", {24'd0, bus.pout}, {24'd0, e});
    chk("ovr_flags", {bus.overrun, bus.pout_valid}, 32'h3);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clear_flags", {bus.overrun, bus.pout_valid}, 32'h0);
    chk("clear_keeps_pout", {24'd0, bus.pout}, 32'h11);

    // clear on the final bit: nothing delivered
    send_bits(8'h77, 7);
    bus.sin = 1'b0; bus.sin_en = 1'b1; bus.clear = 1'b1;
    tick();
    bus.sin_en = 1'b0; bus.clear = 1'b0;
    chk("clear_last_bit", {bus.pout_valid, bus.busy, bus.bit_cnt}, 32'h0);

    // gapped input, then asynchronous abort
    send_bits(8'h07, 3);
    repeat (10) tick();
    chk("gap_hold", {bus.busy, bus.bit_cnt}, {28'd0, 1'b1, 3'd3});
    #2 rstn = 1'b0;
    #1;
    chk("async_abort", {bus.busy, bus.bit_cnt}, 32'h0);
    rstn = 1'b1;
    exp_q.push_back(8'hFF);
    send_bits(8'hFF, 8);
    chk("after_abort", {23'd0, bus.pout_valid, bus.pout}, {23'd0, 1'b1, 8'hFF});
    bus.pout_ready = 1'b1;
    tick();
    bus.pout_ready = 1'b0;

    // accept and complete on the same edge
    exp_q.push_back(8'h55);
    send_bits(8'h55, 8);
    exp_q.push_back(8'hAA);
    send_bits(8'hAA, 7);
    bus.sin = 1'b1; bus.sin_en = 1'b1; bus.pout_ready = 1'b1;
    tick();
    bus.sin_en = 1'b0; bus.pout_ready = 1'b0;
    chk("simul_word", {22'd0, bus.overrun, bus.pout_valid, bus.pout}, {22'd0, 1'b0, 1'b1, 8'hAA});
    bus.pout_ready = 1'b1;
    tick();
    bus.pout_ready = 1'b0;
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rshift_rx.md
# rshift_rx

Serial-in, parallel-out right-shift receiver: the receiving end of the shift-register serial link. It samples one bit per enabled clock into a right-shifting register, LSB first, so the first bit received ends up at bit 0. Each completed word is presented on a parallel port with a valid/ready handshake, and words lost to back-pressure are reported. It sits downstream of the left-shift/parallel-load transmitter and reconstructs the words that transmitter serialises.

## Interface
- WIDTH, 8, word width in bits (≥2)
- CNT_W, $clog2(WIDTH), width of bit_cnt
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous, active-low reset
- sin  input  1  serial data bit
- sin_en  input  1  sample sin on this edge
- clear  input  1  synchronous flush; abandons the partial word and clears all flags
- pout  output  WIDTH  last completed word
- pout_valid  output  1  pout holds an unconsumed word
- pout_ready  input  1  consumer accepts pout when high together with pout_valid
- bit_cnt  output  CNT_W  bits collected in the current partial word (0..WIDTH-1)
- busy  output  1  high while state is SHIFT
- overrun  output  1  sticky; a completed word was dropped

## Operation
- Reset (rstn=0, asynchronous): shreg=0, pout=0, pout_valid=0, bit_cnt=0, overrun=0, busy=0, state=IDLE.
- States:
  - IDLE: bit_cnt=0.
    - sin_en → SHIFT, with bit_cnt=1.
  - SHIFT: collecting bits.
    - sin_en with bit_cnt=WIDTH-1 → word complete, state returns to IDLE.
- Shift on every sin_en edge (not clear): shreg ← {sin, shreg[WIDTH-1:1]}.
- bit_cnt increments on each shift and wraps from WIDTH-1 to 0 on word completion.
- Word completion (sin_en while bit_cnt=WIDTH-1):
  - The completed word is {sin, shreg[WIDTH-1:1]}.
  - If pout_valid=0, or pout_valid=1 and pout_ready=1 on the same edge: pout ← completed word, pout_valid ← 1.
  - Otherwise the new word is dropped, pout and pout_valid are unchanged, and overrun ← 1.
- Handshake: pout_valid falls on the edge where pout_valid and pout_ready are both high, unless a word completes on that same edge (covered above).
- pout is stable while pout_valid=1 and not accepted.
- sin_en=0: shreg, bit_cnt and state hold; gaps between bits are allowed of any length.
- clear (priority over sin_en and pout_ready): shreg=0, bit_cnt=0, state=IDLE, pout_valid=0, overrun=0; pout keeps its value.
- overrun is cleared only by clear or reset.

## Timing
- All outputs are registered; nothing combinational from input to output.
- Latency: pout and pout_valid update on the same rising edge that samples the WIDTH-th bit, so they are visible in the following cycle.
- Back-to-back words with sin_en held high: one word per WIDTH cycles, with no dead cycle between words.
- Consumer holding pout_ready=1: sustains full rate, with pout_valid high for one cycle per word.
- Reset mid-word: the partial word is discarded immediately (asynchronous). The first sin_en after rstn rises is bit 0 of a new word.
- clear on the same edge as the final bit of a word: no word is delivered and pout_valid=0.
- pout_ready while pout_valid=0: ignored.

## Test plan
- Reset / idle: rstn=0 for 2 clocks, then 5 idle clocks → all outputs 0; bit_cnt=0; busy=0.
- Single word: sin_en=1 for 8 clocks with sin=1,0,0,0,0,0,0,0 → after the 8th edge pout=8'h01 and pout_valid=1.
  - Then pout_ready=1 for 1 clock → pout_valid=0 and pout stays 8'h01.
- Back-to-back streaming, pout_ready tied 1:
  - Stimulus: 8'hA5 then 8'h3C, LSB first, 16 consecutive sin_en cycles.
  - Response: pout_valid pulses on edges 8 and 16, with pout=8'hA5 then 8'h3C; overrun=0.
- Overrun:
  - Stimulus: pout_ready=0 throughout; send 8'h11 then 8'h22.
  - Response: pout=8'h11, pout_valid=1, overrun=1 after edge 16.
  - Then: clear → pout_valid=0 and overrun=0.
- Gapped input and abort:
  - Send 3 bits, idle 10 clocks → bit_cnt=3, busy=1.
  - Pulse rstn low mid-cycle → bit_cnt=0 immediately.
  - Then send 8'hFF → pout=8'hFF.
- Simultaneous accept and complete:
  - Stimulus: pout_valid=1 with 8'h55; pout_ready=1 on the edge the final bit of 8'hAA is sampled.
  - Response: pout=8'hAA, pout_valid stays 1, overrun=0.
